spi_slave_tx: RTL and testbench

//  Synthesizable SPI responder (3-wire, slave->master data only); the far end of the top-level SPI master's sclk/cs_n/sdata.

---
 rtl/spi_slave_tx_pkg.sv | 20 ++
 rtl/spi_slave_tx_if.sv | 28 ++
 rtl/spi_slave_tx_sync_edge_det.sv | 31 +++
 rtl/spi_slave_tx.sv | 160 ++++++++++++++++
 tb/tb_spi_slave_tx.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_tx_pkg.sv
// Shared SPI definitions: frame state encoding and mode-3 edge selection, common to
// the SPI master and this responder.
package spi_slave_tx_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StTail  = 2'd2
  } spi_state_e;

  // Mode 3: sclk idles high, data changes on the falling edge, master samples on rising.
  localparam bit SpiCpol        = 1'b1;
  localparam bit SpiShiftOnFall = 1'b1;
  localparam bit SdataIdle      = 1'b1;

  function automatic int unsigned cnt_width(input int unsigned data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/spi_slave_tx_if.sv
// Local transmit handshake, SPI pins and frame status of the SPI responder.
interface spi_slave_tx_if #(
  parameter int unsigned DATA_W = 8
);

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              sclk;
  logic              cs_n;
  logic              sdata;
  logic              sdata_oe;
  logic              busy;
  logic              done;
  logic              underrun;
  logic              abort;

  modport slave (
    input  tx_data, tx_valid, sclk, cs_n,
    output tx_ready, sdata, sdata_oe, busy, done, underrun, abort
  );

  modport master (
    output tx_data, tx_valid, sclk, cs_n,
    input  tx_ready, sdata, sdata_oe, busy, done, underrun, abort
  );

endinterface

// File: rtl/spi_slave_tx_sync_edge_det.sv
// Synchronizes one asynchronous pin into clk and produces 1-clk rise/fall pulses.
module spi_slave_tx_sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          RESET_VAL   = 1'b1
) (
  input  logic clk,
  input  logic n_rst,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   level;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_tx.sv
// SPI responder (mode 3, slave->master only): one DATA_W-bit word per cs_n frame, MSB
// first, fed from a single-entry holding register on a valid/ready handshake.
module spi_slave_tx
  import spi_slave_tx_pkg::*;
#(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] FILL        = {DATA_W{1'b1}}
) (
  input logic            clk,
  input logic            n_rst,
  spi_slave_tx_if.slave  bus
);

  localparam int unsigned     CntW    = cnt_width(DATA_W);
  localparam logic [CntW-1:0] CntFull = CntW'(DATA_W);

  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic sck_count, sck_shift;

  spi_slave_tx_sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (SpiCpol)
  ) u_sync_sclk (
    .clk      (clk),
    .n_rst    (n_rst),
    .async_in (bus.sclk),
    .rise     (sck_rise),
    .fall     (sck_fall)
  );

  spi_slave_tx_sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b1)
  ) u_sync_cs (
    .clk      (clk),
    .n_rst    (n_rst),
    .async_in (bus.cs_n),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  assign sck_shift = SpiShiftOnFall ? sck_fall : sck_rise;
  assign sck_count = SpiShiftOnFall ? sck_rise : sck_fall;

  spi_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic              sdata_q, sdata_d;
  logic              done_p, underrun_p, abort_p;
  logic              accept, bypass;

  assign accept = bus.tx_valid & ~hold_full_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sdata_d     = sdata_q;
    done_p      = 1'b0;
    underrun_p  = 1'b0;
    abort_p     = 1'b0;
    bypass      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
          end else if (bus.tx_valid) begin
            // Word offered in the very clk the frame starts goes straight to the shifter.
            shift_d = bus.tx_data;
            bypass  = 1'b1;
          end else begin
            shift_d    = FILL;
            underrun_p = 1'b1;
          end
          sdata_d = shift_d[DATA_W-1];
          cnt_d   = '0;
          state_d = StShift;
        end
      end

      StShift: begin
        if (sck_count) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CntFull) begin
            done_p  = 1'b1;
            state_d = StTail;
          end
        end else if (sck_shift && cnt_q != '0) begin
          // The first falling edge precedes any sample, so the MSB is still pending.
          shift_d = {shift_q[DATA_W-2:0], 1'b1};
          sdata_d = shift_d[DATA_W-1];
        end
        if (cs_rise) begin
          abort_p = ~done_p;
          state_d = StIdle;
          sdata_d = SdataIdle;
          cnt_d   = '0;
        end
      end

      StTail: begin
        if (sck_shift) begin
          shift_d = {shift_q[DATA_W-2:0], 1'b1};
          sdata_d = shift_d[DATA_W-1];
        end
        if (cs_rise) begin
          state_d = StIdle;
          sdata_d = SdataIdle;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = StIdle;
        sdata_d = SdataIdle;
        cnt_d   = '0;
      end
    endcase

    if (accept && !bypass) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shift_q     <= FILL;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sdata_q     <= SdataIdle;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sdata_q     <= sdata_d;
    end
  end

  assign bus.tx_ready = ~hold_full_q;
  assign bus.sdata    = sdata_q;
  assign bus.sdata_oe = (state_q != StIdle);
  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = done_p;
  assign bus.underrun = underrun_p;
  assign bus.abort    = abort_p;

endmodule

// File: tb/tb_spi_slave_tx.sv
// Bench for spi_slave_tx: behavioural mode-3 master plus a word-queue reference model.
module tb_spi_slave_tx;

  localparam int HALF = 12;

  logic clk;
  logic n_rst;

  spi_slave_tx_if #(.DATA_W(8)) bus ();

  spi_slave_tx #(
    .DATA_W      (8),
    .SYNC_STAGES (2),
    .FILL        (8'hFF)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int und_cnt = 0;
  int abt_cnt = 0;

  // Reference model: words the slave has accepted but not yet sent.
  logic [7:0] model_q[$];

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
    if (bus.underrun === 1'b1) und_cnt++;
    if (bus.abort === 1'b1) abt_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (bus.tx_ready) ok = 1'b1;
      wait_clk(1);
    end
    bus.tx_valid = 1'b0;
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL push_timeout: tx_ready never 1 for %h", d);
    end else begin
      model_q.push_back(d);
    end
  endtask

  function automatic logic [7:0] model_next();
    if (model_q.size() > 0) return model_q.pop_front();
    return 8'hFF;
  endfunction

  // One master frame of n_rise sclk cycles; optionally offers a word in the cs_fall clk.
  task automatic xfer(input int n_rise, input bit inject, input logic [7:0] inj,
                      output logic [15:0] rx, output bit rdy_pre, output bit rdy_post,
                      output bit oe_mid);
    rx = '0;
    bus.cs_n = 1'b0;
    wait_clk(2);
    rdy_pre = bus.tx_ready;
    if (inject) begin
      bus.tx_data  = inj;
      bus.tx_valid = 1'b1;
    end
    wait_clk(1);
    rdy_post     = bus.tx_ready;
    oe_mid       = bus.sdata_oe & bus.busy;
    bus.tx_valid = 1'b0;
    wait_clk(HALF - 3);
    for (int i = 0; i < n_rise; i++) begin
      bus.sclk = 1'b0;
      wait_clk(HALF);
      bus.sclk = 1'b1;
      rx = {rx[14:0], bus.sdata};
      wait_clk(HALF);
    end
    bus.cs_n = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic test_reset();
    n_vec++; if (bus.tx_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", bus.tx_ready); end
    n_vec++; if (bus.sdata !== 1'b1) begin n_err++; $display("FAIL rst_sdata: got %b want 1", bus.sdata); end
    n_vec++; if (bus.sdata_oe !== 1'b0) begin n_err++; $display("FAIL rst_oe: got %b want 0", bus.sdata_oe); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    n_vec++;
    if ({bus.done, bus.underrun, bus.abort} !== 3'b000) begin
      n_err++;
      $display("FAIL rst_pulses: got %b want 000", {bus.done, bus.underrun, bus.abort});
    end
  endtask

  // Full frame with a word (or none) queued beforehand; checks data, pulses and ready timing.
  task automatic run_frame(input string name, input bit queue, input logic [7:0] w);
    logic [15:0] rx;
    logic [7:0]  exp;
    bit pre, post, oe, exp_und;
    int d0, u0, a0;
    if (queue) push_word(w);
    exp_und = (model_q.size() == 0);
    exp = model_next();
    d0 = done_cnt; u0 = und_cnt; a0 = abt_cnt;
    xfer(8, 1'b0, 8'h00, rx, pre, post, oe);
    n_vec++; if (rx[7:0] !== exp) begin n_err++; $display("FAIL %s_data: got %h want %h", name, rx[7:0], exp); end
    n_vec++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL %s_done: got %0d want 1", name, done_cnt - d0); end
    n_vec++;
    if (und_cnt - u0 != int'(exp_und)) begin
      n_err++; $display("FAIL %s_underrun: got %0d want %0d", name, und_cnt - u0, exp_und);
    end
    n_vec++; if (abt_cnt - a0 != 0) begin n_err++; $display("FAIL %s_abort: got %0d want 0", name, abt_cnt - a0); end
    n_vec++; if (pre !== exp_und) begin n_err++; $display("FAIL %s_ready_pre: got %b want %b", name, pre, exp_und); end
    n_vec++; if (post !== 1'b1) begin n_err++; $display("FAIL %s_ready_post: got %b want 1", name, post); end
    n_vec++; if (oe !== 1'b1) begin n_err++; $display("FAIL %s_oe_mid: got %b want 1", name, oe); end
    n_vec++;
    if ({bus.busy, bus.sdata_oe, bus.sdata} !== 3'b001) begin
      n_err++; $display("FAIL %s_idle: got %b want 001", name, {bus.busy, bus.sdata_oe, bus.sdata});
    end
  endtask

  task automatic test_refill();
    logic [15:0] rx;
    bit pre, post, oe;
    push_word(8'hC6);
    void'(model_next());
    fork
      xfer(8, 1'b0, 8'h00, rx, pre, post, oe);
      begin wait_clk(60); push_word(8'hC7); end
    join
    n_vec++; if (rx[7:0] !== 8'hC6) begin n_err++; $display("FAIL refill_first: got %h want c6", rx[7:0]); end
    n_vec++; if (bus.tx_ready !== 1'b0) begin n_err++; $display("FAIL refill_ready_between: got %b want 0", bus.tx_ready); end
    run_frame("refill_second", 1'b0, 8'h00);
  endtask

  task automatic test_abort();
    logic [15:0] rx;
    bit pre, post, oe;
    int d0, a0;
    push_word(8'hA3);
    void'(model_next());
    d0 = done_cnt; a0 = abt_cnt;
    xfer(4, 1'b0, 8'h00, rx, pre, post, oe);
    n_vec++; if (rx[3:0] !== 4'hA) begin n_err++; $display("FAIL abort_bits: got %h want a", rx[3:0]); end
    n_vec++; if (abt_cnt - a0 != 1) begin n_err++; $display("FAIL abort_pulse: got %0d want 1", abt_cnt - a0); end
    n_vec++; if (done_cnt - d0 != 0) begin n_err++; $display("FAIL abort_done: got %0d want 0", done_cnt - d0); end
    n_vec++;
    if ({bus.sdata_oe, bus.sdata} !== 2'b01) begin
      n_err++; $display("FAIL abort_idle: got %b want 01", {bus.sdata_oe, bus.sdata});
    end
    run_frame("after_abort", 1'b1, 8'h5A);
  endtask

  task automatic test_reset_midframe();
    push_word(8'hC8);
    bus.cs_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 3; i++) begin
      bus.sclk = 1'b0; wait_clk(HALF);
      bus.sclk = 1'b1; wait_clk(HALF);
    end
    bus.sclk = 1'b0;
    wait_clk(5);
    #2 n_rst = 1'b0;
    #1;
    model_q.delete();
    test_reset();
    bus.sclk = 1'b1;
    bus.cs_n = 1'b1;
    wait_clk(5);
    n_rst = 1'b1;
    wait_clk(5);
    run_frame("post_reset", 1'b1, 8'h3C);
  endtask

  task automatic test_bypass();
    logic [15:0] rx;
    bit pre, post, oe;
    int u0;
    u0 = und_cnt;
    xfer(8, 1'b1, 8'h81, rx, pre, post, oe);
    n_vec++; if (rx[7:0] !== 8'h81) begin n_err++; $display("FAIL bypass_data: got %h want 81", rx[7:0]); end
    n_vec++; if (und_cnt - u0 != 0) begin n_err++; $display("FAIL bypass_underrun: got %0d want 0", und_cnt - u0); end
    n_vec++; if (post !== 1'b1) begin n_err++; $display("FAIL bypass_hold_empty: got %b want 1", post); end
  endtask

  task automatic test_tail();
    logic [15:0] rx;
    bit pre, post, oe;
    int d0, a0;
    push_word(8'h96);
    void'(model_next());
    d0 = done_cnt; a0 = abt_cnt;
    xfer(12, 1'b0, 8'h00, rx, pre, post, oe);
    n_vec++; if (rx[11:0] !== 12'h96F) begin n_err++; $display("FAIL tail_bits: got %h want 96f", rx[11:0]); end
    n_vec++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL tail_done: got %0d want 1", done_cnt - d0); end
    n_vec++; if (abt_cnt - a0 != 0) begin n_err++; $display("FAIL tail_abort: got %0d want 0", abt_cnt - a0); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_frame("random", 1'($urandom_range(0, 1)), 8'($urandom));
    end
  endtask

  initial begin
    n_rst        = 1'b0;
    bus.sclk     = 1'b1;
    bus.cs_n     = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    #22 n_rst = 1'b1;
    wait_clk(3);
    test_reset();
    run_frame("single", 1'b1, 8'hC5);
    test_refill();
    run_frame("underrun", 1'b0, 8'h00);
    test_abort();
    test_reset_midframe();
    test_bypass();
    test_tail();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
